fft_frame_ctrl: RTL and testbench

- Sequencer wrapped around the 64-point FFT core.
- Collects a stream of complex samples into the core's parallel input arrays and pulses the core's start.
- Waits a fixed compute latency, then streams the 64 parallel results back out over a valid/ready interface.
- Lets upstream and downstream logic use the FFT without driving 64-wide arrays directly.

---
 rtl/fft_frame_ctrl_if.sv | 58 +++++
 rtl/fft_frame_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_ctrl_if
//  Description : Bundle of every non-clock/reset signal of fft_frame_ctrl:
//                the sample input stream, the parallel arrays to and from the
//                64-point FFT core, the core start strobe, the result output
//                stream and the frame abort / frame-done controls.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    abort                   frame abort request (sync to clk)
//    in_valid/in_ready       sample stream handshake
//    in_re/in_im   [W]       sample components
//    fft_in_re/im  [W] x N   parallel arrays presented to the FFT core
//    fft_start               FFT core start strobe
//    fft_out_re/im [W] x N   parallel results returned by the FFT core
//    out_valid/out_ready     result stream handshake
//    out_re/out_im [W]       result components
//    out_last                marks result N-1
//    frame_done              one-cycle pulse on the final result handshake
//  Modports
//    slave  : the frame controller
//    master : the surrounding system (upstream, downstream and FFT core)
// ============================================================================
interface fft_frame_ctrl_if #(
  parameter int N = 64,
  parameter int W = 16
);
  logic         abort;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_re;
  logic [W-1:0] in_im;
  logic [W-1:0] fft_in_re  [N];
  logic [W-1:0] fft_in_im  [N];
  logic         fft_start;
  logic [W-1:0] fft_out_re [N];
  logic [W-1:0] fft_out_im [N];
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_re;
  logic [W-1:0] out_im;
  logic         out_last;
  logic         frame_done;

  modport slave (
    input  abort, in_valid, in_re, in_im, fft_out_re, fft_out_im, out_ready,
    output in_ready, fft_in_re, fft_in_im, fft_start,
           out_valid, out_re, out_im, out_last, frame_done
  );

  modport master (
    output abort, in_valid, in_re, in_im, fft_out_re, fft_out_im, out_ready,
    input  in_ready, fft_in_re, fft_in_im, fft_start,
           out_valid, out_re, out_im, out_last, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_ctrl
//  Description : Frame sequencer around an N-point parallel FFT core.
//                Gathers N streamed complex samples into the core's input
//                arrays, strobes the core's start for START_CYCLES cycles,
//                waits FFT_LATENCY cycles and then streams the N parallel
//                results out in natural order over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk   in   system clock, rising edge
//    rst   in   asynchronous reset, active low
//    bus   slave modport of fft_frame_ctrl_if:
//            abort, in_valid, in_re, in_im, fft_out_re/im, out_ready   (in)
//            in_ready, fft_in_re/im, fft_start, out_valid, out_re,
//            out_im, out_last, frame_done                             (out)
//  Parameters
//    N             points per frame (power of 2)
//    W             bits per real/imag component
//    START_CYCLES  cycles fft_start is held high (>=1)
//    FFT_LATENCY   cycles waited after fft_start falls (>=1)
// ============================================================================
module fft_frame_ctrl #(
  parameter int N            = 64,
  parameter int W            = 16,
  parameter int START_CYCLES = 1,
  parameter int FFT_LATENCY  = 64
) (
  input  wire logic        clk,
  input  wire logic        rst,
  fft_frame_ctrl_if.slave  bus
);

  localparam int IW      = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_MAX = (START_CYCLES > FFT_LATENCY) ? START_CYCLES : FFT_LATENCY;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [IW-1:0] c_idx_last   = IW'(N - 1);
  localparam logic [CW-1:0] c_start_last = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] c_wait_last  = CW'(FFT_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_fft_start;
  logic          r_out_valid;
  logic          r_out_last;
  logic          r_frame_done;
  logic [W-1:0]  r_in_re [N];
  logic [W-1:0]  r_in_im [N];

  state_t        w_state_nxt;
  logic [IW-1:0] w_idx_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_in_ready_nxt;
  logic          w_fft_start_nxt;
  logic          w_out_valid_nxt;
  logic          w_out_last_nxt;
  logic          w_frame_done_nxt;
  logic          w_wr_en;

  logic          w_accept;
  logic          w_beat;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_beat   = r_out_valid & bus.out_ready;

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt;
    w_in_ready_nxt   = r_in_ready;
    w_fft_start_nxt  = r_fft_start;
    w_out_valid_nxt  = r_out_valid;
    w_out_last_nxt   = r_out_last;
    w_frame_done_nxt = 1'b0;
    w_wr_en          = 1'b0;

    if (bus.abort) begin
      // Abort wins over any accept or beat in the same cycle; a sample
      // offered alongside it is dropped because w_wr_en stays low.
      w_state_nxt     = ST_LOAD;
      w_idx_nxt       = '0;
      w_cnt_nxt       = '0;
      w_in_ready_nxt  = 1'b1;
      w_fft_start_nxt = 1'b0;
      w_out_valid_nxt = 1'b0;
      w_out_last_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          // in_ready comes out of reset low and rises on the first edge.
          w_in_ready_nxt = 1'b1;
          if (w_accept) begin
            w_wr_en = 1'b1;
            if (r_idx == c_idx_last) begin
              w_state_nxt     = ST_START;
              w_idx_nxt       = '0;
              w_cnt_nxt       = '0;
              w_in_ready_nxt  = 1'b0;
              w_fft_start_nxt = 1'b1;
            end else begin
              w_idx_nxt = r_idx + IW'(1);
            end
          end
        end

        ST_START: begin
          if (r_cnt == c_start_last) begin
            w_state_nxt     = ST_WAIT;
            w_cnt_nxt       = '0;
            w_fft_start_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end

        ST_WAIT: begin
          if (r_cnt == c_wait_last) begin
            w_state_nxt     = ST_UNLOAD;
            w_cnt_nxt       = '0;
            w_out_valid_nxt = 1'b1;
            w_out_last_nxt  = (r_idx == c_idx_last);
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end

        ST_UNLOAD: begin
          if (w_beat) begin
            if (r_idx == c_idx_last) begin
              w_state_nxt      = ST_LOAD;
              w_idx_nxt        = '0;
              w_out_valid_nxt  = 1'b0;
              w_out_last_nxt   = 1'b0;
              w_in_ready_nxt   = 1'b1;
              w_frame_done_nxt = 1'b1;
            end else begin
              w_idx_nxt      = r_idx + IW'(1);
              // out_last is registered, so it is computed from the index
              // that the next beat will present.
              w_out_last_nxt = ((r_idx + IW'(1)) == c_idx_last);
            end
          end
        end

        default: begin
          w_state_nxt     = ST_LOAD;
          w_idx_nxt       = '0;
          w_cnt_nxt       = '0;
          w_in_ready_nxt  = 1'b0;
          w_fft_start_nxt = 1'b0;
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_LOAD;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_in_ready   <= 1'b0;
      r_fft_start  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_in_ready   <= w_in_ready_nxt;
      r_fft_start  <= w_fft_start_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_last   <= w_out_last_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FFT input arrays: only an accepted sample writes, so the arrays keep the
  // last full frame until the next frame's first accept overwrites slot 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        r_in_re[i] <= '0;
        r_in_im[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_in_re[r_idx] <= bus.in_re;
      r_in_im[r_idx] <= bus.in_im;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < N; g++) begin : g_fft_in
    assign bus.fft_in_re[g] = r_in_re[g];
    assign bus.fft_in_im[g] = r_in_im[g];
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.fft_start  = r_fft_start;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_last   = r_out_last;
  assign bus.frame_done = r_frame_done;

  // Result mux follows the live index; zero outside the unload phase.
  assign bus.out_re = (r_state == ST_UNLOAD) ? bus.fft_out_re[r_idx] : '0;
  assign bus.out_im = (r_state == ST_UNLOAD) ? bus.fft_out_im[r_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_frame_ctrl
//  Description : Self-checking bench for fft_frame_ctrl. A stub FFT returns
//                in[i]+1 on both components. Accepted samples build a frame
//                model; each completed frame pushes its N expected results
//                into a queue that an independent monitor drains on every
//                output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_ctrl;
  localparam int N   = 64;
  localparam int W   = 16;
  localparam int SC  = 2;
  localparam int LAT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_frame_ctrl_if #(.N(N), .W(W)) bus ();

  fft_frame_ctrl #(.N(N), .W(W), .START_CYCLES(SC), .FFT_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stub FFT core: each result is its input plus one.
  for (genvar g = 0; g < N; g++) begin : g_stub
    assign bus.fft_out_re[g] = bus.fft_in_re[g] + 16'd1;
    assign bus.fft_out_im[g] = bus.fft_in_im[g] + 16'd1;
  end

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         last;
  } beat_t;

  beat_t        exp_q [$];
  logic [W-1:0] part_re [$];
  logic [W-1:0] part_im [$];
  logic [W-1:0] last_re [N];
  logic [W-1:0] last_im [N];

  int checks   = 0;
  int errors   = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  bit pending_done = 1'b0;
  bit rdy_rand     = 1'b0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_accept(input logic [W-1:0] re, input logic [W-1:0] im);
    beat_t b;
    part_re.push_back(re);
    part_im.push_back(im);
    if (part_re.size() == N) begin
      for (int i = 0; i < N; i++) begin
        last_re[i] = part_re[i];
        last_im[i] = part_im[i];
        b.re   = part_re[i] + 16'd1;
        b.im   = part_im[i] + 16'd1;
        b.last = (i == N - 1);
        exp_q.push_back(b);
      end
      part_re.delete();
      part_im.delete();
    end
  endtask

  // Abort or reset throws away everything in flight.
  task automatic model_flush(input bit clear_arrays);
    exp_q.delete();
    part_re.delete();
    part_im.delete();
    pending_done = 1'b0;
    if (clear_arrays)
      for (int i = 0; i < N; i++) begin
        last_re[i] = '0;
        last_im[i] = '0;
      end
  endtask

  task automatic check_fft_in(input string name);
    int bad = -1;
    int b;
    for (int i = 0; i < N; i++)
      if (bad < 0 && (bus.fft_in_re[i] !== last_re[i] || bus.fft_in_im[i] !== last_im[i]))
        bad = i;
    b = (bad < 0) ? 0 : bad;
    chk(bad < 0, $sformatf("%s[%0d]", name, b),
        {bus.fft_in_re[b], bus.fft_in_im[b]}, {last_re[b], last_im[b]});
  endtask

  // ---------------- stimulus ----------------
  task automatic send_frame(input int n, input bit rand_valid, input bit ramp);
    int acc = 0;
    int cyc = 0;
    logic [W-1:0] re;
    logic [W-1:0] im;
    re = ramp ? 16'd0    : W'($urandom);
    im = ramp ? 16'hFFFF : W'($urandom);
    while (acc < n) begin
      @(posedge clk); #1;
      bus.in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_re    = re;
      bus.in_im    = im;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        model_accept(re, im);
        acc++;
        if (ramp) begin
          re = W'(acc);
          im = 16'hFFFF - W'(acc);
        end else begin
          re = W'($urandom);
          im = W'($urandom);
        end
      end
      cyc++;
      if (cyc > 3000) begin
        chk(1'b0, "send_timeout", acc, n);
        return;
      end
    end
  endtask

  task automatic finish_send();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int tgt = done_cnt + 1;
    for (int c = 0; c < 3000 && done_cnt < tgt; c++) @(posedge clk);
    chk(done_cnt >= tgt, name, done_cnt, tgt);
    @(negedge clk);
    chk(exp_q.size() == 0, {name, "_drain"}, exp_q.size(), 0);
  endtask

  // Downstream ready: either always on or a 50% coin per cycle.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : p_mon
    beat_t e;
    if (rst === 1'b1) begin
      if (pending_done) begin
        chk(bus.frame_done && bus.in_ready && !bus.out_valid, "frame_done_pulse",
            {bus.frame_done, bus.in_ready, bus.out_valid}, 3'b110);
        pending_done = 1'b0;
        done_cnt++;
      end else begin
        chk(!bus.frame_done, "frame_done_spurious", bus.frame_done, 0);
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_out_valid", {bus.out_re, bus.out_im}, 0);
        end else begin
          e = exp_q[0];
          chk({bus.out_re, bus.out_im, bus.out_last} === e, "out_beat",
              {bus.out_re, bus.out_im, bus.out_last}, e);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            beat_cnt++;
            if (e.last) pending_done = 1'b1;
          end
        end
      end else begin
        chk(bus.out_re == '0 && bus.out_im == '0 && !bus.out_last, "out_idle_zero",
            {bus.out_re, bus.out_im, bus.out_last}, 0);
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int n_start, first_start, lat, base;
    bit rdy_seen, valid_seen;

    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_re    = '0;
    bus.in_im    = '0;
    model_flush(1'b1);

    // Reset held for three cycles.
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk({bus.in_ready, bus.fft_start, bus.out_valid, bus.out_last, bus.frame_done} == 5'b0,
          "reset_outputs",
          {bus.in_ready, bus.fft_start, bus.out_valid, bus.out_last, bus.frame_done}, 0);
    end
    check_fft_in("reset_fft_in");
    #1 rst = 1'b1;
    #1 chk(!bus.in_ready, "in_ready_before_edge", bus.in_ready, 0);
    @(negedge clk);
    chk(bus.in_ready, "in_ready_first_edge", bus.in_ready, 1);

    // Back-to-back ramp frame with latency and start-width measurement.
    send_frame(N, 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.in_re = W'(N);
    bus.in_im = 16'hFFFF - W'(N);
    n_start = 0; first_start = -1; lat = -1; rdy_seen = 1'b0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (bus.in_ready) rdy_seen = 1'b1;
      if (bus.fft_start) begin
        n_start++;
        if (first_start < 0) first_start = j;
      end
      if (bus.out_valid) begin
        lat = j;
        break;
      end
      if (j == 3) bus.in_valid = 1'b0;
    end
    chk(first_start == 0, "fft_start_begin", first_start, 0);
    chk(n_start == SC, "fft_start_width", n_start, SC);
    chk(lat == SC + LAT, "out_valid_latency", lat, SC + LAT);
    chk(!rdy_seen, "in_ready_low_after_frame", rdy_seen, 0);
    check_fft_in("ramp_fft_in");
    wait_done("ramp_frame_done");

    // Random valid / random ready frames.
    rdy_rand = 1'b1;
    for (int f = 0; f < 3; f++) begin
      send_frame(N, 1'b1, 1'b0);
      finish_send();
      check_fft_in("bp_fft_in");
      wait_done("bp_frame_done");
    end

    // Abort while waiting on the core.
    rdy_rand = 1'b0;
    send_frame(N, 1'b0, 1'b0);
    finish_send();
    repeat (SC + 3) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(negedge clk);
    model_flush(1'b0);
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk(bus.in_ready, "abort_wait_in_ready", bus.in_ready, 1);
    valid_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) valid_seen = 1'b1;
    end
    chk(!valid_seen, "abort_wait_no_valid", valid_seen, 0);
    send_frame(N, 1'b1, 1'b0);
    finish_send();
    check_fft_in("post_abort_fft_in");
    wait_done("post_abort_done");

    // Abort in the middle of loading, with a sample offered alongside it.
    send_frame(30, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_re    = W'($urandom);
    bus.in_im    = W'($urandom);
    @(negedge clk);
    model_flush(1'b0);
    @(posedge clk); #1;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    send_frame(N, 1'b1, 1'b0);
    finish_send();
    check_fft_in("abort_load_fft_in");
    wait_done("abort_load_done");

    // Asynchronous reset in the middle of unloading.
    base = beat_cnt;
    send_frame(N, 1'b0, 1'b0);
    finish_send();
    for (int c = 0; c < 500 && beat_cnt < base + 20; c++) begin
      @(posedge clk); #1;
    end
    chk(beat_cnt == base + 20, "reach_beat20", beat_cnt - base, 20);
    chk(bus.out_valid, "valid_before_reset", bus.out_valid, 1);
    #1 rst = 1'b0;
    #1;
    chk(!bus.out_valid && bus.out_re == '0 && !bus.in_ready && !bus.fft_start,
        "async_reset_clear", {bus.out_valid, bus.out_re, bus.in_ready, bus.fft_start}, 0);
    model_flush(1'b1);
    check_fft_in("async_reset_fft_in");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    send_frame(N, 1'b1, 1'b0);
    finish_send();
    check_fft_in("post_reset_fft_in");
    wait_done("post_reset_done");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
